// File: rtl/ir_pipe_ctrl_pkg.sv
// Shared DLX definitions for the IR pipeline controller.
//   - DLX_NOP: bubble encoding (SLL r0,r0,0)
//   - opcode / field constants used by the surrounding DLX datapath
//   - interlock FSM state encoding and cycle-mode priority encoding
package ir_pipe_ctrl_pkg;

  localparam logic [31:0] DLX_NOP = 32'h0000_0000;

  // Opcode field and a few commonly referenced primary opcodes.
  localparam int unsigned OP_MSB     = 31;
  localparam int unsigned OP_LSB     = 26;
  localparam logic [5:0]  OP_SPECIAL = 6'h00;
  localparam logic [5:0]  OP_J       = 6'h02;
  localparam logic [5:0]  OP_BEQZ    = 6'h04;
  localparam logic [5:0]  OP_LW      = 6'h23;
  localparam logic [5:0]  OP_SW      = 6'h2b;

  typedef enum logic [0:0] {
    StRun,
    StLdStall
  } ctrl_state_e;

  // Cycle mode, listed from lowest to highest priority.
  typedef enum logic [1:0] {
    ModeNormal,
    ModeSquash,
    ModeStall,
    ModeHold
  } mode_e;

  // Fixed priority: hold > stall > squash (live or pending) > normal.
  function automatic mode_e decode_mode(input logic hold, input logic stall, input logic kill);
    if (hold) begin
      return ModeHold;
    end else if (stall) begin
      return ModeStall;
    end else if (kill) begin
      return ModeSquash;
    end
    return ModeNormal;
  endfunction

endpackage

// File: rtl/ir_pipe_ctrl_if.sv
// Handshake bundle between the IR pipeline controller and its IF / hazard-unit neighbours.
//   master: fetch + hazard side (drives IRin/IRin_valid/stall/squash/hold, observes the rest)
//   slave : ir_pipe_ctrl
//   CNT_W : width of the stall-event counter
interface ir_pipe_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  logic [31:0]      IRin;
  logic             IRin_valid;
  logic             stall;
  logic             squash;
  logic             hold;
  logic [31:0]      IRid;
  logic [31:0]      IRex;
  logic [31:0]      IRmem;
  logic [31:0]      IRwb;
  logic             Vid;
  logic             Vex;
  logic             Vmem;
  logic             Vwb;
  logic             PCen;
  logic [CNT_W-1:0] stall_cnt;
  logic             stall_err;
  logic             squash_pending;

  modport master (
    output IRin, IRin_valid, stall, squash, hold,
    input  IRid, IRex, IRmem, IRwb, Vid, Vex, Vmem, Vwb, PCen, stall_cnt, stall_err,
    input  squash_pending
  );

  modport slave (
    input  IRin, IRin_valid, stall, squash, hold,
    output IRid, IRex, IRmem, IRwb, Vid, Vex, Vmem, Vwb, PCen, stall_cnt, stall_err,
    output squash_pending
  );
endinterface

// File: rtl/ir_stage_reg.sv
// One pipeline stage instruction register: 32-bit IR plus valid bit.
//   clk, rst : clock, asynchronous active-high reset (clears to NOP_WORD / invalid)
//   en       : load this cycle; otherwise hold
//   bubble   : when loading, load NOP_WORD / invalid instead of ir_in / valid_in
//   ir_in, valid_in : upstream stage contents
//   ir, valid       : registered stage contents
module ir_stage_reg #(
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        bubble,
  input  logic [31:0] ir_in,
  input  logic        valid_in,
  output logic [31:0] ir,
  output logic        valid
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ir    <= NOP_WORD;
      valid <= 1'b0;
    end else if (en) begin
      if (bubble) begin
        ir    <= NOP_WORD;
        valid <= 1'b0;
      end else begin
        ir    <= ir_in;
        valid <= valid_in;
      end
    end
  end

endmodule

// File: rtl/ir_pipe_ctrl.sv
// DLX instruction-register pipeline controller (ID/EX/MEM/WB).
//   CLK, RESET : clock, asynchronous active-high reset
//   bus        : ir_pipe_ctrl_if slave -- fetched instruction, stall/squash/hold requests in;
//                stage IRs, valid bits, PCen, stall counter, sticky error and pending-squash out
// Modes per cycle: HOLD freezes everything, STALL keeps ID and injects a bubble into EX,
// SQUASH kills the instruction coming from IF, NORMAL shifts the pipe.
module ir_pipe_ctrl
  import ir_pipe_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W    = 16,
  parameter logic [31:0] NOP_WORD = DLX_NOP
) (
  input  logic           CLK,
  input  logic           RESET,
  ir_pipe_ctrl_if.slave  bus
);

  ctrl_state_e      state_q;
  logic             squash_pending_q;
  logic [CNT_W-1:0] stall_cnt_q;
  logic             stall_err_q;

  mode_e mode;
  logic  id_en;
  logic  id_bubble;
  logic  pipe_en;
  logic  ex_bubble;

  logic [31:0] ir_id, ir_ex, ir_mem, ir_wb;
  logic        v_id, v_ex, v_mem, v_wb;

  // A squash seen during stall/hold is remembered and applied on the next shifting cycle.
  assign mode = decode_mode(bus.hold, bus.stall, bus.squash | squash_pending_q);

  assign id_en     = (mode == ModeNormal) || (mode == ModeSquash);
  assign id_bubble = (mode == ModeSquash) || !bus.IRin_valid;
  assign pipe_en   = (mode != ModeHold);
  assign ex_bubble = (mode == ModeStall);

  assign bus.PCen = !bus.hold && !bus.stall;

  ir_stage_reg #(.NOP_WORD(NOP_WORD)) u_id (
    .clk      (CLK),
    .rst      (RESET),
    .en       (id_en),
    .bubble   (id_bubble),
    .ir_in    (bus.IRin),
    .valid_in (bus.IRin_valid),
    .ir       (ir_id),
    .valid    (v_id)
  );

  ir_stage_reg #(.NOP_WORD(NOP_WORD)) u_ex (
    .clk      (CLK),
    .rst      (RESET),
    .en       (pipe_en),
    .bubble   (ex_bubble),
    .ir_in    (ir_id),
    .valid_in (v_id),
    .ir       (ir_ex),
    .valid    (v_ex)
  );

  ir_stage_reg #(.NOP_WORD(NOP_WORD)) u_mem (
    .clk      (CLK),
    .rst      (RESET),
    .en       (pipe_en),
    .bubble   (1'b0),
    .ir_in    (ir_ex),
    .valid_in (v_ex),
    .ir       (ir_mem),
    .valid    (v_mem)
  );

  ir_stage_reg #(.NOP_WORD(NOP_WORD)) u_wb (
    .clk      (CLK),
    .rst      (RESET),
    .en       (pipe_en),
    .bubble   (1'b0),
    .ir_in    (ir_mem),
    .valid_in (v_mem),
    .ir       (ir_wb),
    .valid    (v_wb)
  );

  // Interlock FSM with its registered side outputs.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q          <= StRun;
      squash_pending_q <= 1'b0;
      stall_cnt_q      <= '0;
      stall_err_q      <= 1'b0;
    end else begin
      unique case (mode)
        ModeHold: begin
          if (bus.squash) begin
            squash_pending_q <= 1'b1;
          end
        end
        ModeStall: begin
          // Back-to-back load-use stalls are a hazard-unit protocol violation.
          if (state_q == StLdStall) begin
            stall_err_q <= 1'b1;
          end
          if (stall_cnt_q != {CNT_W{1'b1}}) begin
            stall_cnt_q <= stall_cnt_q + 1'b1;
          end
          if (bus.squash) begin
            squash_pending_q <= 1'b1;
          end
          state_q <= StLdStall;
        end
        ModeSquash: begin
          squash_pending_q <= 1'b0;
          state_q          <= StRun;
        end
        ModeNormal: begin
          state_q <= StRun;
        end
        default: begin
          state_q <= StRun;
        end
      endcase
    end
  end

  assign bus.IRid           = ir_id;
  assign bus.IRex           = ir_ex;
  assign bus.IRmem          = ir_mem;
  assign bus.IRwb           = ir_wb;
  assign bus.Vid            = v_id;
  assign bus.Vex            = v_ex;
  assign bus.Vmem           = v_mem;
  assign bus.Vwb            = v_wb;
  assign bus.stall_cnt      = stall_cnt_q;
  assign bus.stall_err      = stall_err_q;
  assign bus.squash_pending = squash_pending_q;

endmodule

// File: tb/tb_ir_pipe_ctrl.sv
// Self-checking bench for ir_pipe_ctrl: directed scenarios plus randomized traffic
// compared against a stage-array reference model.
module tb_ir_pipe_ctrl;

  localparam int unsigned CNT_W  = 2;
  localparam int          CNT_MAX = (1 << CNT_W) - 1;
  localparam logic [31:0] NOP    = 32'h0000_0000;
  localparam logic [31:0] LW     = 32'h8C22_0004;

  logic CLK = 1'b0;
  logic RESET;

  ir_pipe_ctrl_if #(.CNT_W(CNT_W)) bus ();

  ir_pipe_ctrl #(
    .CNT_W    (CNT_W),
    .NOP_WORD (NOP)
  ) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus.slave)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Reference model: stage k of the pipe (0=ID .. 3=WB), plus side state.
  logic [31:0] m_ir[4];
  logic        m_v[4];
  logic        m_pend;
  int          m_cnt;
  logic        m_err;
  logic        m_last_stall;

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_ir[i] = NOP;
      m_v[i]  = 1'b0;
    end
    m_pend       = 1'b0;
    m_cnt        = 0;
    m_err        = 1'b0;
    m_last_stall = 1'b0;
  endtask

  // Apply the cycle rules to the model using the inputs about to be clocked.
  task automatic model_edge();
    logic kill;
    if (bus.hold) begin
      if (bus.squash) m_pend = 1'b1;
    end else if (bus.stall) begin
      if (m_cnt < CNT_MAX) m_cnt++;
      if (m_last_stall) m_err = 1'b1;
      m_last_stall = 1'b1;
      if (bus.squash) m_pend = 1'b1;
      m_ir[3] = m_ir[2]; m_v[3] = m_v[2];
      m_ir[2] = m_ir[1]; m_v[2] = m_v[1];
      m_ir[1] = NOP;     m_v[1] = 1'b0;
    end else begin
      kill = bus.squash || m_pend;
      m_pend = 1'b0;
      m_last_stall = 1'b0;
      for (int i = 3; i > 0; i--) begin
        m_ir[i] = m_ir[i-1];
        m_v[i]  = m_v[i-1];
      end
      m_v[0]  = bus.IRin_valid && !kill;
      m_ir[0] = m_v[0] ? bus.IRin : NOP;
    end
  endtask

  task automatic set_in(input logic [31:0] ir, input logic v, input logic st,
                        input logic sq, input logic h);
    bus.IRin       = ir;
    bus.IRin_valid = v;
    bus.stall      = st;
    bus.squash     = sq;
    bus.hold       = h;
  endtask

  task automatic tick();
    model_edge();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    set_in(NOP, 1'b0, 1'b0, 1'b0, 1'b0);
    model_reset();
    @(posedge CLK);
    #1;
    RESET = 1'b0;
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    set_in(NOP, 1'b0, 1'b0, 1'b0, 1'b0);
    model_reset();
    #2;
    checks++;
    if ({bus.IRid, bus.IRex, bus.IRmem, bus.IRwb} !== {4{NOP}}) begin
      errors++;
      $display("FAIL reset_irs: got %h %h %h %h, want all %h", bus.IRid, bus.IRex,
               bus.IRmem, bus.IRwb, NOP);
    end
    checks++;
    if ({bus.Vid, bus.Vex, bus.Vmem, bus.Vwb, bus.stall_err, bus.squash_pending} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b%b%b%b err=%b pend=%b, want 0", bus.Vid, bus.Vex,
               bus.Vmem, bus.Vwb, bus.stall_err, bus.squash_pending);
    end
    checks++;
    if (bus.stall_cnt !== '0) begin
      errors++;
      $display("FAIL reset_cnt: got %0d, want 0", bus.stall_cnt);
    end
    checks++;
    if (bus.PCen !== 1'b1) begin
      errors++;
      $display("FAIL reset_pcen_idle: got %b, want 1", bus.PCen);
    end
    bus.stall = 1'b1;
    #1;
    checks++;
    if (bus.PCen !== 1'b0) begin
      errors++;
      $display("FAIL reset_pcen_stall: got %b, want 0", bus.PCen);
    end
    bus.stall = 1'b0;
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    // First edge after reset release is a normal cycle.
    set_in(32'h2002_0011, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    checks++;
    if (bus.IRid !== 32'h2002_0011 || bus.Vid !== 1'b1) begin
      errors++;
      $display("FAIL first_edge: IRid=%h Vid=%b, want 20020011 1", bus.IRid, bus.Vid);
    end
  endtask

  task automatic test_latency();
    do_reset();
    set_in(LW, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    set_in(NOP, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      checks++;
      if (bus.IRwb !== NOP || bus.Vwb !== 1'b0) begin
        errors++;
        $display("FAIL lat_early_wb k=%0d: IRwb=%h Vwb=%b, want NOP 0", k, bus.IRwb, bus.Vwb);
      end
      tick();
    end
    checks++;
    if (bus.IRwb !== LW || bus.Vwb !== 1'b1 || {bus.IRid, bus.IRex, bus.IRmem} !== {3{NOP}}) begin
      errors++;
      $display("FAIL lat_wb: IRwb=%h Vwb=%b id/ex/mem=%h %h %h, want %h 1 NOP", bus.IRwb,
               bus.Vwb, bus.IRid, bus.IRex, bus.IRmem, LW);
    end
  endtask

  task automatic test_stall_single();
    do_reset();
    set_in(LW, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    set_in(32'h0043_2020, 1'b1, 1'b1, 1'b0, 1'b0);
    #1;
    checks++;
    if (bus.PCen !== 1'b0) begin
      errors++;
      $display("FAIL stall_pcen: got %b, want 0", bus.PCen);
    end
    tick();
    checks++;
    if (bus.IRid !== LW || bus.IRex !== NOP || bus.Vex !== 1'b0 || bus.stall_cnt !== 2'd1 ||
        bus.stall_err !== 1'b0) begin
      errors++;
      $display("FAIL stall_one: IRid=%h IRex=%h Vex=%b cnt=%0d err=%b, want %h NOP 0 1 0",
               bus.IRid, bus.IRex, bus.Vex, bus.stall_cnt, bus.stall_err, LW);
    end
    bus.stall = 1'b0;
    tick();
    checks++;
    if (bus.IRex !== LW || bus.IRid !== 32'h0043_2020) begin
      errors++;
      $display("FAIL stall_resume: IRex=%h IRid=%h, want %h 00432020", bus.IRex, bus.IRid, LW);
    end
  endtask

  task automatic test_stall_double();
    do_reset();
    set_in(LW, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    checks++;
    if (bus.stall_err !== 1'b0) begin
      errors++;
      $display("FAIL dbl_first: err=%b, want 0", bus.stall_err);
    end
    tick();
    checks++;
    if (bus.stall_err !== 1'b1) begin
      errors++;
      $display("FAIL dbl_second: err=%b, want 1", bus.stall_err);
    end
    bus.stall = 1'b0;
    tick();
    tick();
    checks++;
    if (bus.stall_err !== 1'b1) begin
      errors++;
      $display("FAIL dbl_sticky: err=%b, want 1", bus.stall_err);
    end
  endtask

  task automatic test_squash_stall();
    do_reset();
    set_in(LW, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    set_in(32'h1111_2222, 1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    checks++;
    if (bus.IRid !== LW || bus.squash_pending !== 1'b1) begin
      errors++;
      $display("FAIL sq_stall: IRid=%h pend=%b, want %h 1", bus.IRid, bus.squash_pending, LW);
    end
    set_in(32'h3333_4444, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    checks++;
    if (bus.IRid !== NOP || bus.Vid !== 1'b0 || bus.squash_pending !== 1'b0 ||
        bus.IRex !== LW) begin
      errors++;
      $display("FAIL sq_apply: IRid=%h Vid=%b pend=%b IRex=%h, want NOP 0 0 %h", bus.IRid,
               bus.Vid, bus.squash_pending, bus.IRex, LW);
    end
    tick();
    checks++;
    if (bus.IRid !== 32'h3333_4444 || bus.Vid !== 1'b1) begin
      errors++;
      $display("FAIL sq_once: IRid=%h Vid=%b, want 33334444 1", bus.IRid, bus.Vid);
    end
  endtask

  task automatic test_hold();
    logic [31:0] w[4];
    do_reset();
    for (int i = 0; i < 4; i++) begin
      w[i] = $urandom | 32'h1;
      set_in(w[i], 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
    end
    for (int c = 0; c < 3; c++) begin
      set_in($urandom, 1'b1, c == 1, c == 2, 1'b1);
      #1;
      checks++;
      if (bus.PCen !== 1'b0) begin
        errors++;
        $display("FAIL hold_pcen c=%0d: got %b, want 0", c, bus.PCen);
      end
      tick();
      checks++;
      if ({bus.IRwb, bus.IRmem, bus.IRex, bus.IRid} !== {w[0], w[1], w[2], w[3]} ||
          bus.stall_cnt !== '0 || {bus.Vid, bus.Vex, bus.Vmem, bus.Vwb} !== 4'hf) begin
        errors++;
        $display("FAIL hold_frozen c=%0d: wb..id=%h %h %h %h cnt=%0d, want %h %h %h %h 0", c,
                 bus.IRwb, bus.IRmem, bus.IRex, bus.IRid, bus.stall_cnt, w[0], w[1], w[2], w[3]);
      end
    end
    // Squash raised during hold must kill the next fetched instruction.
    set_in(32'h5555_6666, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    checks++;
    if (bus.IRwb !== w[1] || bus.IRid !== NOP || bus.Vid !== 1'b0) begin
      errors++;
      $display("FAIL hold_release: IRwb=%h IRid=%h Vid=%b, want %h NOP 0", bus.IRwb, bus.IRid,
               bus.Vid, w[1]);
    end
  endtask

  task automatic test_saturate_and_async_reset();
    do_reset();
    for (int k = 0; k < 5; k++) begin
      set_in($urandom, 1'b1, 1'b1, 1'b0, 1'b0);
      tick();
      bus.stall = 1'b0;
      tick();
      checks++;
      if (bus.stall_cnt !== CNT_W'((k + 1 > CNT_MAX) ? CNT_MAX : k + 1) || bus.stall_err !== 1'b0)
      begin
        errors++;
        $display("FAIL sat k=%0d: cnt=%0d err=%b, want %0d 0", k, bus.stall_cnt, bus.stall_err,
                 (k + 1 > CNT_MAX) ? CNT_MAX : k + 1);
      end
    end
    set_in(LW, 1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    #2;
    RESET = 1'b1;
    #1;
    checks++;
    if ({bus.IRid, bus.IRex, bus.IRmem, bus.IRwb} !== {4{NOP}} ||
        {bus.Vid, bus.Vex, bus.Vmem, bus.Vwb} !== 4'b0 || bus.stall_cnt !== '0 ||
        bus.stall_err !== 1'b0 || bus.squash_pending !== 1'b0 || bus.PCen !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: ir=%h %h %h %h v=%b%b%b%b cnt=%0d err=%b pend=%b pcen=%b",
               bus.IRid, bus.IRex, bus.IRmem, bus.IRwb, bus.Vid, bus.Vex, bus.Vmem, bus.Vwb,
               bus.stall_cnt, bus.stall_err, bus.squash_pending, bus.PCen);
    end
    do_reset();
  endtask

  task automatic test_random();
    logic [31:0] ir;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if (i % 100 == 99) do_reset();
      ir = $urandom;
      set_in(ir, $urandom_range(0, 9) < 8, $urandom_range(0, 99) < 15,
             $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 10);
      #1;
      checks++;
      if (bus.PCen !== (!bus.hold && !bus.stall)) begin
        errors++;
        $display("FAIL rnd_pcen i=%0d: got %b, hold=%b stall=%b", i, bus.PCen, bus.hold,
                 bus.stall);
      end
      tick();
      checks++;
      if ({bus.IRid, bus.IRex, bus.IRmem, bus.IRwb, bus.Vid, bus.Vex, bus.Vmem, bus.Vwb,
           bus.stall_cnt, bus.stall_err, bus.squash_pending} !==
          {m_ir[0], m_ir[1], m_ir[2], m_ir[3], m_v[0], m_v[1], m_v[2], m_v[3],
           CNT_W'(m_cnt), m_err, m_pend}) begin
        errors++;
        $display("FAIL rnd_state i=%0d: got ir=%h %h %h %h v=%b%b%b%b cnt=%0d err=%b pend=%b; want ir=%h %h %h %h v=%b%b%b%b cnt=%0d err=%b pend=%b",
                 i, bus.IRid, bus.IRex, bus.IRmem, bus.IRwb, bus.Vid, bus.Vex, bus.Vmem,
                 bus.Vwb, bus.stall_cnt, bus.stall_err, bus.squash_pending, m_ir[0], m_ir[1],
                 m_ir[2], m_ir[3], m_v[0], m_v[1], m_v[2], m_v[3], m_cnt, m_err, m_pend);
      end
    end
  endtask

  initial begin
    RESET = 1'b1;
    set_in(NOP, 1'b0, 1'b0, 1'b0, 1'b0);
    test_reset();
    test_latency();
    test_stall_single();
    test_stall_double();
    test_squash_stall();
    test_hold();
    test_saturate_and_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ir_pipe_ctrl.md
IR_PIPE_CTRL -- requirements
Module: ir_pipe_ctrl

Interface
REQ-001 Parameter CNT_W, default 16, width of the stall-event counter.
REQ-002 Parameter NOP_WORD, default 32'h0000_0000, bubble encoding (SLL r0,r0,0).
REQ-003 CLK  input  1  single clock; all state updates on its rising edge.
REQ-004 RESET  input  1  asynchronous, active-high reset.
REQ-005 IRin  input  32  fetched instruction from IF.
REQ-006 IRin_valid  input  1  IRin holds a real instruction this cycle.
REQ-007 stall  input  1  load-use interlock request from the ID bypass/hazard unit.
REQ-008 squash  input  1  taken branch/jump resolved in ID; kill the instruction in IF.
REQ-009 hold  input  1  memory wait; freeze the whole pipe.
REQ-010 IRid, IRex, IRmem, IRwb  output  32 each  stage instruction registers, fed back to the hazard unit.
REQ-011 Vid, Vex, Vmem, Vwb  output  1 each  stage holds a non-bubble instruction.
REQ-012 PCen  output  1  IF may advance the PC and accept IRin.
REQ-013 stall_cnt  output  CNT_W  saturating count of stall cycles taken.
REQ-014 stall_err  output  1  sticky protocol error flag.

Function
REQ-015 Cycle modes use fixed priority: hold > stall > squash/pending > normal.
REQ-016 HOLD: all IR, valid and pending registers keep their values; PCen=0; stall_cnt is unchanged.
REQ-017 STALL (stall=1, hold=0): IRid holds; IRex<=NOP_WORD with Vex<=0; IRmem<=IRex; IRwb<=IRmem; PCen=0.
REQ-018 STALL cycles increment stall_cnt by 1, saturating at all-ones with no wrap.
REQ-019 NORMAL: IRid<=IRin and Vid<=IRin_valid (NOP_WORD if IRin_valid=0); IRex<=IRid; IRmem<=IRex; IRwb<=IRmem; valid bits shift with their IRs; PCen=1.
REQ-020 SQUASH in a non-stall, non-hold cycle: as NORMAL, except IRid<=NOP_WORD and Vid<=0.
REQ-021 squash asserted together with stall or hold sets squash_pending.
REQ-022 squash_pending is applied as SQUASH on the first following NORMAL-eligible cycle, then clears.
REQ-023 A squash that arrives while pending is already set does not double-apply.
REQ-024 PCen is combinational: !hold && !stall.
REQ-025 Latency: an instruction accepted at edge N reaches IRwb at edge N+3 when no stall or hold occurs.
REQ-026 Each STALL cycle adds 1 cycle of latency; each HOLD cycle adds 1 cycle of latency.
REQ-027 Track the interlock as a 2-state FSM, RUN and LDSTALL.
REQ-028 FSM transitions: RUN->LDSTALL on a STALL cycle; LDSTALL->RUN on a non-hold cycle with stall=0; hold keeps the current state.
REQ-029 A stall in LDSTALL with hold=0 (second consecutive load-use stall) sets stall_err=1.
REQ-030 stall_err stays set until RESET.
REQ-031 stall_err does not change pipeline behaviour.

Reset
REQ-032 While RESET=1 (asynchronous): IRid/IRex/IRmem/IRwb=NOP_WORD, all V*=0, stall_cnt=0, stall_err=0, squash_pending=0, FSM=RUN.
REQ-033 While RESET=1, PCen follows REQ-024.
REQ-034 Reset asserted mid-stall or mid-hold discards all in-flight instructions and any pending squash.
REQ-035 The first edge after RESET deasserts behaves as a NORMAL cycle.

Structure
REQ-036 NOP_WORD, the FSM state encoding and the mode-priority encoding live in the shared DLX defines file alongside the opcode and field macros.
REQ-037 One sub-module, ir_stage_reg: 32-bit IR plus valid register, with enable and bubble-insert inputs, instantiated four times.
REQ-038 The FSM, squash_pending, stall_cnt and stall_err stay in the top module.

Verification
REQ-039 Reset then IRin=0x8C220004 (LW r2,4(r1)) valid for 1 cycle -> IRwb=0x8C220004 and Vwb=1 exactly 4 edges later; IRid/IRex/IRmem are NOP between.
REQ-040 LW in ID at edge 1, stall=1 for one cycle at edge 2 -> IRid held, IRex=NOP with Vex=0, PCen=0 that cycle, stall_cnt=1, stall_err=0.
REQ-041 stall=1 for 2 consecutive cycles -> stall_err=1 after the 2nd edge and remains 1 after stall drops.
REQ-042 squash=1 with stall=1 in the same cycle -> IRid holds during the stall; on the next cycle IRid=NOP and Vid=0 even though IRin_valid=1; squash_pending then 0.
REQ-043 hold=1 for 3 cycles with a full pipe -> all four IRs and stall_cnt unchanged and PCen=0; stall during hold is not counted.
REQ-044 CNT_W=2, 5 isolated stalls -> stall_cnt saturates at 3; RESET asserted mid-stall -> all outputs at reset values immediately, before the next CLK edge.
